dataset_load_ctrl: RTL and testbench

Sequencer for the dataset-loading front end. It accepts a bit-serial stream of data-point records and assembles each record (features plus y value, 16 bits per field) in a shift register. It writes each completed record to the record RAM at consecutive addresses. After the last record it hands RAM ownership to the compute engine until that engine reports completion.

---
 rtl/dataset_load_ctrl.sv | 155 +++++++++++++++
 tb/tb_dataset_load_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataset_load_ctrl.sv
// Dataset-load sequencer: assembles bit-serial records into RAM words, then hands the RAM
// port to the compute engine until it reports completion. Optional macro: SER_PARITY_EN.
module dataset_load_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
    parameter int DEPTH        = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_dp,
    input  logic [3:0]            feat,
    input  logic                  ser_valid,
    input  logic                  ser,
    output logic                  ser_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [ADDR_WIDTH-1:0] comp_addr,
    output logic                  comp_grant,
    input  logic                  comp_done,
    output logic                  busy,
    output logic                  loaded,
    output logic                  err
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        COMPUTE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] num_dp_r;
    logic [3:0]            feat_r;
    logic [ADDR_WIDTH-1:0] rec_idx;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  err_r;

    logic             cfg_bad;
    logic [CNT_W-1:0] w_last;
    logic             at_par;
    logic             par_bad;
    logic             rec_end;
    logic             last_rec;

    assign cfg_bad  = (num_dp == '0) || (num_dp > ADDR_WIDTH'(DEPTH));
    assign w_last   = CNT_W'(LENGTH * (int'(feat_r) + 1) - 1);
    assign last_rec = (rec_idx == num_dp_r - 1'b1);

`ifdef SER_PARITY_EN
    // The parity bit sits one index past the record and is never stored.
    assign at_par  = (bit_cnt == w_last + 1'b1);
    assign par_bad = at_par && ser_valid && ((^shift_reg) != ser);
    assign rec_end = at_par && ser_valid && !par_bad;
`else
    assign at_par  = 1'b0;
    assign par_bad = 1'b0;
    assign rec_end = ser_valid && (bit_cnt == w_last);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = cfg_bad ? IDLE : SHIFT;
                end
            end
            SHIFT: begin
                if (par_bad) begin
                    state_next = IDLE;
                end else if (rec_end) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_rec ? COMPUTE : SHIFT;
            end
            COMPUTE: begin
                if (comp_done) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            num_dp_r  <= '0;
            feat_r    <= '0;
            rec_idx   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_dp_r  <= num_dp;
                        feat_r    <= feat;
                        rec_idx   <= '0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        err_r     <= cfg_bad;
                    end
                end
                SHIFT: begin
                    if (ser_valid) begin
                        if (par_bad) begin
                            err_r <= 1'b1;
                        end else if (!at_par) begin
                            shift_reg[bit_cnt[IDX_W-1:0]] <= ser;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    rec_idx   <= rec_idx + 1'b1;
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ser_ready  = (state == SHIFT);
    assign ram_we     = (state == WRITE);
    assign comp_grant = (state == COMPUTE);
    assign busy       = (state == SHIFT) || (state == WRITE) || (state == COMPUTE);
    assign loaded     = (state == COMPUTE) || (state == DONE);
    assign err        = err_r;
    assign ram_addr   = (state == COMPUTE) ? comp_addr : rec_idx;
    assign ram_wdata  = shift_reg;

endmodule

// File: tb/tb_dataset_load_ctrl.sv
// Self-checking bench for dataset_load_ctrl: directed scenarios plus randomized loads
// compared against expected RAM contents derived from the generated record words.
module tb_dataset_load_ctrl;

    localparam int AW = 12;
    localparam int DW = 256;
`ifdef SER_PARITY_EN
    localparam int PAR_EXTRA = 1;
`else
    localparam int PAR_EXTRA = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_dp = '0;
    logic [3:0]    feat = '0;
    logic          ser_valid = 1'b0;
    logic          ser = 1'b0;
    logic          ser_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] comp_addr = '0;
    logic          comp_grant;
    logic          comp_done = 1'b0;
    logic          busy;
    logic          loaded;
    logic          err;

    int tests_run = 0;
    int tests_failed = 0;
    int write_count = 0;
    int expected_writes = 0;
    int cyc = 0;
    int first_cyc = 0;
    logic [DW-1:0] recs[$];

    dataset_load_ctrl dut (
        .CLK(CLK), .RST(RST), .start(start), .num_dp(num_dp), .feat(feat),
        .ser_valid(ser_valid), .ser(ser), .ser_ready(ser_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .comp_addr(comp_addr), .comp_grant(comp_grant), .comp_done(comp_done),
        .busy(busy), .loaded(loaded), .err(err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ram_we === 1'b1) write_count <= write_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_ser_ready", ser_ready, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        checkOutput("rst_comp_grant", comp_grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_loaded", loaded, 0);
        checkOutput("rst_err", err, 0);
    endtask

    task automatic startLoad(input int n, input int f);
        start  = 1'b1;
        num_dp = AW'(n);
        feat   = 4'(f);
        nextCycle();
        start  = 1'b0;
    endtask

    task automatic makeRandomRecs(input int f, input int n);
        int w;
        logic [DW-1:0] word;
        w = 16 * (f + 1);
        recs.delete();
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < DW / 32; k++) word[k*32 +: 32] = $urandom;
            for (int b = w; b < DW; b++) word[b] = 1'b0;
            recs.push_back(word);
        end
    endtask

    // Streams every record in recs LSB first and checks each write as it happens.
    task automatic applyStimulus(input int f, input int n, input bit stalls, input bit check_timing);
        int w;
        w = 16 * (f + 1);
        startLoad(n, f);
        checkOutput("start_ready", ser_ready, 1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_clears_err", err, 0);
        for (int r = 0; r < n; r++) begin
            for (int b = 0; b < w; b++) begin
                if (stalls && $urandom_range(0, 15) == 0) begin
                    ser_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) nextCycle();
                    checkOutput("stall_ready", ser_ready, 1);
                end
                ser_valid = 1'b1;
                ser = recs[r][b];
                if (r == 0 && b == 0) first_cyc = cyc;
                nextCycle();
            end
`ifdef SER_PARITY_EN
            ser = ^recs[r];
            nextCycle();
`endif
            ser_valid = 1'b0;
            checkOutput("write_we", ram_we, 1);
            checkOutput("write_addr", ram_addr, r);
            checkOutput("write_data", ram_wdata, recs[r]);
            checkOutput("write_ready", ser_ready, 0);
            nextCycle();
        end
        expected_writes += n;
        checkOutput("compute_grant", comp_grant, 1);
        checkOutput("compute_busy", busy, 1);
        checkOutput("compute_loaded", loaded, 1);
        checkOutput("compute_we", ram_we, 0);
        if (check_timing) checkOutput("compute_latency", cyc - first_cyc, w + 1 + PAR_EXTRA);
    endtask

    task automatic finishCompute(input int n);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 4095));
        comp_addr = a;
        #1;
        checkOutput("comp_addr_pass", ram_addr, a);
        comp_done = 1'b1;
        nextCycle();
        comp_done = 1'b0;
        checkOutput("done_grant", comp_grant, 0);
        checkOutput("done_loaded", loaded, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_addr", ram_addr, n);
        checkOutput("write_count", write_count, expected_writes);
    endtask

    initial begin
        int f;
        int n;
        logic [DW-1:0] word;

        #12;
        checkResetValues();
        @(negedge CLK);
        RST = 1'b1;
        nextCycle();

        recs.delete();
        recs.push_back(DW'(16'h1234));
        recs.push_back(DW'(16'hABCD));
        applyStimulus(0, 2, 1'b0, 1'b0);
        comp_addr = AW'(5);
        #1;
        checkOutput("comp_addr_5", ram_addr, 5);
        finishCompute(2);

        recs.delete();
        word = '0;
        for (int b = 0; b < DW; b++) word[b] = ~b[0];
        recs.push_back(word);
        applyStimulus(15, 1, 1'b0, 1'b1);
        start = 1'b1;
        num_dp = AW'(2);
        comp_done = 1'b1;
        nextCycle();
        start = 1'b0;
        comp_done = 1'b0;
        checkOutput("done_wins_grant", comp_grant, 0);
        checkOutput("done_wins_loaded", loaded, 1);
        checkOutput("done_wins_ready", ser_ready, 0);

        startLoad(0, 0);
        checkOutput("zero_err", err, 1);
        checkOutput("zero_idle_busy", busy, 0);
        checkOutput("zero_idle_loaded", loaded, 0);
        startLoad(101, 3);
        checkOutput("over_err", err, 1);
        checkOutput("over_idle_ready", ser_ready, 0);
        nextCycle();
        checkOutput("err_sticky", err, 1);
        checkOutput("err_no_write", write_count, expected_writes);

        startLoad(100, 2);
        checkOutput("depth_ok_err", err, 0);
        checkOutput("depth_ok_ready", ser_ready, 1);
        RST = 1'b0;
        #1;
        RST = 1'b1;
        nextCycle();

        f = $urandom_range(0, 15);
        makeRandomRecs(f, 3);
        startLoad(3, f);
        ser_valid = 1'b1;
        for (int b = 0; b < 7; b++) begin
            ser = recs[0][b];
            nextCycle();
        end
        RST = 1'b0;
        #1;
        checkResetValues();
        ser_valid = 1'b0;
        nextCycle();
        RST = 1'b1;
        nextCycle();
        checkOutput("rst_no_write", write_count, expected_writes);
        applyStimulus(f, 3, 1'b1, 1'b0);
        finishCompute(3);

        for (int t = 0; t < 4; t++) begin
            f = $urandom_range(0, 15);
            n = $urandom_range(1, 3);
            makeRandomRecs(f, n);
            applyStimulus(f, n, 1'b1, 1'b0);
            finishCompute(n);
        end

`ifdef SER_PARITY_EN
        startLoad(1, 0);
        ser_valid = 1'b1;
        for (int b = 0; b < 16; b++) begin
            ser = (b == 0);
            nextCycle();
        end
        ser = 1'b0;
        nextCycle();
        ser_valid = 1'b0;
        checkOutput("par_bad_err", err, 1);
        checkOutput("par_bad_we", ram_we, 0);
        checkOutput("par_bad_busy", busy, 0);
        nextCycle();
        checkOutput("par_bad_no_write", write_count, expected_writes);
        recs.delete();
        recs.push_back(DW'(16'h0001));
        applyStimulus(0, 1, 1'b0, 1'b1);
        finishCompute(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
